// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the transmit arbiter.
// master = requesters plus the uart_tx busy flag; slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 3
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic [IDW-1:0]       grant_id;
   logic                 active;
   logic                 timeout_err;

   modport master (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, active, timeout_err
   );

   modport slave (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, active, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// state     | meaning
// IDLE      | waiting for a request while the transmitter is idle
// LAUNCH    | tx_start/req_ready pulse for the granted byte
// WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE | frame in flight, waiting for tx_busy to fall
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic              clk,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW  = $clog2(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
   logic [TW-1:0]        busy_timer, busy_timer_nxt;
   logic [7:0]           tx_data_q, tx_data_nxt;
   logic [IDW-1:0]       grant_id_q, grant_id_nxt;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_nxt;
   logic                 tx_start_q, tx_start_nxt;
   logic                 active_q, active_nxt;
   logic                 timeout_err_q, timeout_err_nxt;

   logic                 pick_found;
   logic [IDW-1:0]       pick_id;
   logic [IDW-1:0]       cand;
   int                   idx;

   // Walk from farthest to nearest after rr_ptr so the nearest valid requester wins.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = 0;
      cand       = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = IDW'(idx);
         if (bus.req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      rr_ptr_nxt      = rr_ptr;
      busy_timer_nxt  = busy_timer;
      tx_data_nxt     = tx_data_q;
      grant_id_nxt    = grant_id_q;
      req_ready_nxt   = '0;
      tx_start_nxt    = 1'b0;
      timeout_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.tx_busy && pick_found) begin
               tx_data_nxt            = bus.req_data[8*pick_id +: 8];
               grant_id_nxt           = pick_id;
               rr_ptr_nxt             = pick_id;
               req_ready_nxt[pick_id] = 1'b1;
               tx_start_nxt           = 1'b1;
               state_nxt              = LAUNCH;
            end
         end
         LAUNCH: begin
            busy_timer_nxt = TW'(BUSY_TIMEOUT - 1);
            state_nxt      = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (busy_timer == '0) begin
               // Transmitter never picked the byte up; drop it, keep rr_ptr advanced.
               timeout_err_nxt = 1'b1;
               state_nxt       = IDLE;
            end else begin
               busy_timer_nxt = busy_timer - 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      active_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rr_ptr        <= IDW'(NUM_REQ - 1);
         busy_timer    <= '0;
         tx_data_q     <= '0;
         grant_id_q    <= '0;
         req_ready_q   <= '0;
         tx_start_q    <= 1'b0;
         active_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         rr_ptr        <= rr_ptr_nxt;
         busy_timer    <= busy_timer_nxt;
         tx_data_q     <= tx_data_nxt;
         grant_id_q    <= grant_id_nxt;
         req_ready_q   <= req_ready_nxt;
         tx_start_q    <= tx_start_nxt;
         active_q      <= active_nxt;
         timeout_err_q <= timeout_err_nxt;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.active      = active_q;
   assign bus.timeout_err = timeout_err_q;
endmodule
